// File: rtl/pwls_reg_write_queue.sv
// -----------------------------------------------------------------------------
// pwls_reg_write_queue
//
// Collects byte-wide host register writes and replays them as 16-bit writes
// into the multichannel ALU register port. A low byte is only latched; the
// matching high byte commits {high, latched low} together with the target
// address into a small FIFO. The head entry is written to the ALU whenever the
// ALU offers a write slot.
//
// Optional feature (macro PWLS_WQ_COALESCE_EN):
//   When defined, a high-byte commit whose address matches the newest queued
//   entry overwrites that entry's data instead of taking a new slot. This only
//   happens if that entry is not leaving the queue on the same edge.
//
// Parameters:
//   ADDR_BITS - register address width (matches ALU reg_waddr)
//   DEPTH     - queue entries, power of two, >= 2
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   host byte write request
//   in_ready   out  queue can take a byte write this cycle
//   in_addr    in   target register address (used on high-byte commit)
//   in_byte    in   write byte
//   in_hi      in   0 = low byte (latch), 1 = high byte (commit word)
//   write_slot in   ALU accepts a register write this cycle
//   reg_waddr  out  head entry address (0 when empty)
//   reg_wdata  out  head entry data (0 when empty)
//   reg_we     out  ALU write strobe, head pops on the same edge
//   count      out  number of queued entries
// -----------------------------------------------------------------------------
module pwls_reg_write_queue #(
    parameter int ADDR_BITS = 6,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_BITS-1:0]   in_addr,
    input  logic [7:0]             in_byte,
    input  logic                   in_hi,
    input  logic                   write_slot,
    output logic [ADDR_BITS-1:0]   reg_waddr,
    output logic [15:0]            reg_wdata,
    output logic                   reg_we,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic [7:0]           lo_latch_r;
    logic [ADDR_BITS-1:0] addr_mem_r [DEPTH];
    logic [15:0]          data_mem_r [DEPTH];

    logic          empty_s;
    logic          full_s;
    logic          accept_s;
    logic          commit_s;
    logic          merge_s;
    logic          push_s;
    logic          pop_s;
    logic [PW-1:0] tail_ptr_s;

    // Handshake, strobe, push/pop/merge decisions and head-entry presentation.
    always_comb begin
        empty_s    = (count_r == {CW{1'b0}});
        full_s     = (count_r == CNT_FULL);
        // Both strobes are forced low during reset so in-flight requests and
        // write slots are ignored while the queue is being cleared.
        in_ready   = !rst && !full_s;
        reg_we     = !rst && write_slot && !empty_s;
        pop_s      = reg_we;
        accept_s   = in_valid && in_ready;
        commit_s   = accept_s && in_hi;
        tail_ptr_s = wr_ptr_r - PTR_ONE;
`ifdef PWLS_WQ_COALESCE_EN
        // With a single entry queued and popping, the tail is the head that
        // is being written out now, so it must not be modified.
        merge_s    = commit_s && !empty_s
                     && (addr_mem_r[tail_ptr_s] == in_addr)
                     && !(pop_s && (count_r == CNT_ONE));
`else
        merge_s    = 1'b0;
`endif
        push_s     = commit_s && !merge_s;
        if (!empty_s) begin
            reg_waddr = addr_mem_r[rd_ptr_r];
            reg_wdata = data_mem_r[rd_ptr_r];
        end else begin
            reg_waddr = {ADDR_BITS{1'b0}};
            reg_wdata = 16'h0000;
        end
    end

    // Pointers, occupancy and the low-byte latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            lo_latch_r <= 8'h00;
        end else begin
            if (accept_s && !in_hi) begin
                lo_latch_r <= in_byte;
            end
            // Pointers are PW bits wide, so increments wrap modulo DEPTH.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only visible through a non-zero count, so
    // it needs no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r] <= in_addr;
            data_mem_r[wr_ptr_r] <= {in_byte, lo_latch_r};
        end else if (merge_s) begin
            data_mem_r[tail_ptr_s] <= {in_byte, lo_latch_r};
        end
    end

    assign count = count_r;

endmodule
